// File: rtl/uart_txd.sv
// UART transmitter: 4-entry byte FIFO feeding an 8N1 / 8-parity-1 serializer.
// Bit timing is a divider tick at 8x baud; each bit spans 8 ticks.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (low) for one bit time
// S_DATA  | 8 data bits, LSB first
// S_PARITY| frame parity bit, settings latched at pop
// S_STOP  | stop bit (high); pops next byte at bit end if any
module uart_txd #(
   parameter logic [15:0] DIV = 16'h0032
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       wr_en,
   input  logic       parity_en,
   input  logic       parity_kind,
   output logic       txd,
   output logic       busy,
   output logic       full,
   output logic       empty,
   output logic [2:0] count
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [15:0] DIV_M1 = DIV - 16'd1;

   state_t      state_q, state_d;
   logic [7:0]  mem_q [4];
   logic [7:0]  mem_d [4];
   logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [2:0]  count_q, count_d;
   logic [15:0] div_q, div_d;
   logic [2:0]  sub_q, sub_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_en_q, par_en_d;
   logic        par_bit_q, par_bit_d;
   logic        txd_q, txd_d;
   logic        busy_q, busy_d;

   logic wr_acc, pop, tick, bit_end;

   always_comb begin
      state_d   = state_q;
      mem_d     = mem_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      div_d     = div_q;
      sub_d     = sub_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      pop       = 1'b0;

      wr_acc  = wr_en && (count_q != 3'd4);
      tick    = (state_q != S_IDLE) && (div_q == DIV_M1);
      bit_end = tick && (sub_q == 3'd7);

      if (state_q != S_IDLE) begin
         div_d = tick ? 16'd0 : div_q + 16'd1;
         if (tick) sub_d = sub_q + 3'd1;
      end

      case (state_q)
         S_IDLE:   if (count_q != 3'd0) pop = 1'b1;
         S_START:  if (bit_end) state_d = S_DATA;
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: if (bit_end) state_d = S_STOP;
         S_STOP: begin
            if (bit_end) begin
               if (count_q != 3'd0) pop = 1'b1;
               else                 state_d = S_IDLE;
            end
         end
         default:  state_d = S_IDLE;
      endcase

      // Parity is computed once per frame from the popped byte and the kind at pop time.
      if (pop) begin
         shift_d   = mem_q[rptr_q];
         par_en_d  = parity_en;
         par_bit_d = parity_kind ^ (^mem_q[rptr_q]);
         div_d     = 16'd0;
         sub_d     = 3'd0;
         bit_d     = 3'd0;
         rptr_d    = rptr_q + 2'd1;
         state_d   = S_START;
      end

      if (wr_acc) begin
         mem_d[wptr_q] = din;
         wptr_d        = wptr_q + 2'd1;
      end

      count_d = count_q + {2'b00, wr_acc} - {2'b00, pop};

      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
         S_PARITY: txd_d = par_bit_q;
         default:  txd_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
         wptr_q    <= 2'd0;
         rptr_q    <= 2'd0;
         count_q   <= 3'd0;
         div_q     <= 16'd0;
         sub_q     <= 3'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_q     <= mem_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         div_q     <= div_d;
         sub_q     <= sub_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
      end
   end

   assign txd   = txd_q;
   assign busy  = busy_q;
   assign full  = (count_q == 3'd4);
   assign empty = (count_q == 3'd0);
   assign count = count_q;

endmodule
